// File: rtl/aes_pkg.sv
// Shared AES constants, tables and byte helpers.
// Used by the round engine, its round datapath and its interface users.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    ROUND,
    DONE
  } state_t;

  localparam logic [1:0] KEYLEN_128 = 2'b00;
  localparam logic [1:0] KEYLEN_192 = 2'b01;
  localparam logic [1:0] KEYLEN_256 = 2'b10;
  localparam logic [1:0] KEYLEN_RSV = 2'b11;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // Byte 0 of each table sits in the top byte.
  localparam logic [2047:0] SBOX_T = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_T = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Source byte for each output byte (index = 4*col + row).
  localparam int SR_MAP [16] = '{
    0, 5, 10, 15, 4, 9, 14, 3,
    8, 13, 2, 7, 12, 1, 6, 11
  };
  localparam int ISR_MAP [16] = '{
    0, 13, 10, 7, 4, 1, 14, 11,
    8, 5, 2, 15, 12, 9, 6, 3
  };

  // Column mixing coefficients, rotated per output row.
  localparam logic [7:0] MC_COEF [4] = '{
    8'h02, 8'h03, 8'h01, 8'h01
  };
  localparam logic [7:0] IMC_COEF [4] = '{
    8'h0e, 8'h0b, 8'h0d, 8'h09
  };

  function automatic logic [7:0] sbox(
    input logic [7:0] b
  );
    return SBOX_T[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(
    input logic [7:0] b
  );
    return INV_SBOX_T[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^
      (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] byte_at(
    input logic [127:0] blk,
    input int           idx
  );
    return blk[8*(15-idx) +: 8];
  endfunction

  function automatic logic [3:0] nr_of(
    input logic [1:0] keylen
  );
    logic [3:0] nr;
    unique case (keylen)
      KEYLEN_192: nr = NR_192;
      KEYLEN_256: nr = NR_256;
      default:    nr = NR_128;
    endcase
    return nr;
  endfunction

endpackage

// File: rtl/aes_round_engine_if.sv
// Request, round-key and result handshakes of the AES round engine.
// master = requester/key store side, slave = engine side.
interface aes_round_engine_if;

  logic         in_valid;
  logic         in_ready;
  logic         in_decrypt;
  logic [1:0]   in_keylen;
  logic [127:0] in_block;
  logic [3:0]   key_round;
  logic         key_valid;
  logic [127:0] key_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         out_err;

  modport master (
    output in_valid,
    output in_decrypt,
    output in_keylen,
    output in_block,
    output key_valid,
    output key_data,
    output out_ready,
    input  in_ready,
    input  key_round,
    input  out_valid,
    input  out_block,
    input  out_err
  );

  modport slave (
    input  in_valid,
    input  in_decrypt,
    input  in_keylen,
    input  in_block,
    input  key_valid,
    input  key_data,
    input  out_ready,
    output in_ready,
    output key_round,
    output out_valid,
    output out_block,
    output out_err
  );

endinterface

// File: rtl/aes_round_comb.sv
// One combinational AES round, forward or inverse.
// Ports: block/key in, decrypt selects direction, last drops (Inv)MixColumns; result out.
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] block,
  input  logic [127:0] key,
  input  logic         decrypt,
  input  logic         last,
  output logic [127:0] result
);

  function automatic logic [127:0] mix_cols(
    input logic [127:0] s,
    input logic         inv
  );
    logic [127:0] r;
    logic [7:0]   acc;
    logic [7:0]   cf;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) begin
          cf = inv ? IMC_COEF[(j-i+4)%4]
                   : MC_COEF[(j-i+4)%4];
          acc = acc ^ gmul(byte_at(s, 4*c+j), cf);
        end
        r[8*(15-(4*c+i)) +: 8] = acc;
      end
    end
    return r;
  endfunction

  logic [127:0] enc_s;
  logic [127:0] enc_m;
  logic [127:0] dec_s;
  logic [127:0] dec_a;
  logic [127:0] dec_m;

  // Byte substitution commutes with the byte permutation,
  // so both are folded into one lookup per output byte.
  always_comb begin
    enc_s = '0;
    dec_s = '0;
    for (int i = 0; i < 16; i++) begin
      enc_s[8*(15-i) +: 8] =
        sbox(byte_at(block, SR_MAP[i]));
      dec_s[8*(15-i) +: 8] =
        inv_sbox(byte_at(block, ISR_MAP[i]));
    end
  end

  always_comb begin
    enc_m = mix_cols(enc_s, 1'b0);
    dec_a = dec_s ^ key;
    dec_m = mix_cols(dec_a, 1'b1);
  end

  always_comb begin
    result = '0;
    if (decrypt) result = last ? dec_a : dec_m;
    else         result = (last ? enc_s : enc_m) ^ key;
  end

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES-128/192/256 encrypt/decrypt engine, one round per clock.
// Ports: clk, rst_n (async, active-low), bus = request/key/result handshakes.
module aes_round_engine
  import aes_pkg::*;
#(
  parameter bit ENC_EN    = 1'b1,
  parameter bit DEC_EN    = 1'b1,
  parameter bit KEY192_EN = 1'b1,
  parameter bit KEY256_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  aes_round_engine_if.slave bus
);

  state_t       state;
  state_t       nxt;
  logic [127:0] blk;
  logic [127:0] rnd_out;
  logic [3:0]   kr;
  logic [3:0]   nr;
  logic         dec;
  logic         err;
  logic         last;
  logic         reject;

  always_comb begin
    reject =
      (bus.in_keylen == KEYLEN_RSV) ||
      (bus.in_decrypt ? !DEC_EN : !ENC_EN) ||
      (bus.in_keylen == KEYLEN_192 && !KEY192_EN) ||
      (bus.in_keylen == KEYLEN_256 && !KEY256_EN);
  end

  // The key index doubles as the round counter.
  assign last = dec ? (kr == 4'd0) : (kr == nr);

  aes_round_comb u_round (
    .block   (blk),
    .key     (bus.key_data),
    .decrypt (dec),
    .last    (last),
    .result  (rnd_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:
        if (bus.in_valid)
          nxt = reject ? DONE : INIT;
      INIT:
        if (bus.key_valid) nxt = ROUND;
      ROUND:
        if (bus.key_valid && last) nxt = DONE;
      DONE:
        if (bus.out_ready) nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE:  bus.in_ready  = 1'b1;
      DONE:  bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.out_block = blk;
  assign bus.out_err   = err;
  assign bus.key_round = kr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk <= '0;
      kr  <= '0;
      nr  <= '0;
      dec <= 1'b0;
      err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.in_valid) begin
          blk <= bus.in_block;
          dec <= bus.in_decrypt;
          nr  <= nr_of(bus.in_keylen);
          err <= reject;
          kr  <= (!reject && bus.in_decrypt) ?
                 nr_of(bus.in_keylen) : 4'd0;
        end
        INIT: if (bus.key_valid) begin
          blk <= blk ^ bus.key_data;
          kr  <= dec ? kr - 4'd1 : kr + 4'd1;
        end
        ROUND: if (bus.key_valid) begin
          blk <= rnd_out;
          if (last)     kr <= 4'd0;
          else if (dec) kr <= kr - 4'd1;
          else          kr <= kr + 4'd1;
        end
        DONE: ;
      endcase
    end
  end

endmodule

// File: doc/aes_round_engine.md
# aes_round_engine

Iterative AES block engine, one round per clock, supporting encryption and decryption with AES-128/192/256 selected per request. Sits between the request front-end (valid/ready) and the round-key store: it requests round keys by index, stalls on key latency, and holds each result until the consumer accepts it. Successor to the fixed-mode AES-128 decipher, which it replaces.

## Interface
- ENC_EN, default 1: encryption supported.
- DEC_EN, default 1: decryption supported.
- KEY192_EN, default 1: AES-192 supported.
- KEY256_EN, default 1: AES-256 supported. AES-128 is always supported.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  engine can accept; high only in IDLE.
- in_decrypt  in  1  1 = decrypt, 0 = encrypt.
- in_keylen  in  2  00 = 128, 01 = 192, 10 = 256, 11 = reserved.
- in_block  in  128  input block; bits [127:120] are FIPS-197 byte 0, column-major.
- key_round  out  4  round-key index requested.
- key_valid  in  1  key_data is valid for key_round this cycle.
- key_data  in  128  round key.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_block  out  128  result block.
- out_err  out  1  request was rejected (unsupported or reserved mode); qualified by out_valid.

## Operation
- Nr = 10/12/14 for keylen 00/01/10.
- A request is accepted on in_valid & in_ready. The engine latches block, mode, keylen and Nr.
- Rejected request: keylen 11, a disabled mode, or a disabled key size.
  - Goes straight to DONE with out_block = in_block and out_err = 1.
  - No key requests are issued.
- States:
  - IDLE: in_ready = 1; key_round = 0.
  - INIT: block ^= key.
    - Key index: encrypt 0, decrypt Nr.
    - Advances only when key_valid = 1; otherwise holds and retries.
  - ROUND: one round per cycle, gated by key_valid.
    - Encrypt, indices 1..Nr: SubBytes, ShiftRows, MixColumns (omitted when index = Nr), AddRoundKey.
    - Decrypt, indices Nr-1..0: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns (omitted when index = 0).
    - After the last index → DONE.
  - DONE: out_valid = 1 and out_block / out_err held stable; in_ready = 0. On out_ready → IDLE.
- key_round is registered. It changes only on the edge where a key is consumed (key_valid high in INIT/ROUND) and is stable while key_valid is low.
- Round counter width is 4 bits; the counter never wraps (0..14 only).
- Reset mid-operation: immediate return to IDLE; the in-flight request is discarded.
- in_* inputs are ignored outside IDLE.

## Timing
- Reset values: in_ready 1, out_valid 0, out_err 0, out_block 0, key_round 0; state IDLE.
- Latency with key_valid held high: accept edge at T.
  - INIT runs in cycle T+1.
  - ROUND runs for Nr cycles.
  - out_valid rises in cycle T+Nr+2 (AES-128: 12 cycles).
- Each low cycle of key_valid adds exactly one cycle.
- Rejected request: out_valid rises in cycle T+1.
- Throughput: the next accept is possible the cycle after out_valid & out_ready. There is no overlap: in_ready is low in DONE even while out_ready is high.
- No combinational path from in_valid or out_ready to any output except through state registers. key_data → next-state block is the only long combinational path.

## Structure
- Package aes_pkg holds:
  - sbox and inv_sbox tables.
  - xtime/gmul helpers and the ShiftRows/InvShiftRows byte maps.
  - Nr constants and keylen encodings.
  - The state enum {IDLE, INIT, ROUND, DONE}.
  - The existing shared constants migrate into this package.
- Sub-module aes_round_comb: purely combinational single round.
  - Inputs: block, key, decrypt, last.
  - Output: the round result block.
  - Instantiated once; the engine owns the FSM, counter and registers.

## Test plan
- AES-128 encrypt, key 000102…0f, pt 00112233445566778899aabbccddeeff, key_valid tied high → out_block 69c4e0d86a7b0430d8cdb78070b4c55a, out_err 0, out_valid in cycle T+12.
- AES-192 encrypt with key 000102…17 → dda97ca4864cdfe06eaf70a0ec0d7191; AES-256 encrypt with key 000102…1f → 8ea2b7ca516745bfeafc49904b496089. Decrypt of each ciphertext → 00112233445566778899aabbccddeeff.
- AES-256 decrypt with key_valid randomly low 30% of cycles → correct plaintext, key_round sequence 14,13,…,0 with no skipped index, latency 16 plus the number of stall cycles.
- out_ready held low for 20 cycles → out_valid/out_block stable, in_ready 0, a concurrent in_valid is not accepted.
- keylen 11 with block a5a5…a5 → out_valid at T+1, out_block a5a5…a5, out_err 1; with DEC_EN = 0, a decrypt request behaves the same.
- rst_n asserted at round 5 → all outputs at reset values immediately; the next request completes correctly.
